// File: rtl/shift_sequencer.sv
// Parallel-to-serial shift sequencer: shifts a word out MSB first at one bit per DIV
// clocks while capturing the returned serial stream, then presents the captured word.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             ser_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [DW-1:0]    div_cnt;
  logic             accept;
  logic             bit_end;

  assign accept  = (state == IDLE) && tx_valid && tx_ready;
  assign bit_end = (state == SHIFT) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx_ready is registered so it stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
    end else begin
      tx_ready <= (state_nxt == IDLE);
      rx_valid <= (state == DONE);
      if (accept) begin
        shreg   <= tx_data;
        bit_cnt <= '0;
        div_cnt <= '0;
      end else if (state == SHIFT) begin
        if (bit_end) begin
          shreg   <= {shreg[WIDTH-2:0], ser_in};
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
          div_cnt <= '0;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (state == DONE) begin
        rx_data <= shreg;
      end
    end
  end

  assign ser_en  = (state == SHIFT);
  assign busy    = (state != IDLE);
  assign ser_out = (state == SHIFT) & shreg[WIDTH-1];

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed and randomized transfers against a bit-level
// model of the serial frame, plus a small WIDTH=4/DIV=1 instance.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ser_out;
  logic       ser_drv;
  logic       loop;
  logic       ser_in;
  logic       ser_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  logic [3:0] tx_data1;
  logic       tx_valid1;
  logic       tx_ready1;
  logic       ser_out1;
  logic       ser_en1;
  logic [3:0] rx_data1;
  logic       rx_valid1;
  logic       busy1;

  int         tests = 0;
  int         failed = 0;
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  assign ser_in = loop ? ser_out : ser_drv;

  shift_sequencer #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .ser_out(ser_out), .ser_in(ser_in), .ser_en(ser_en),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
  );

  shift_sequencer #(.WIDTH(4), .DIV(1)) dut1 (
    .clk(clk), .reset(reset), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready1), .ser_out(ser_out1), .ser_in(ser_out1), .ser_en(ser_en1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: loopback, 1: random ser_in every cycle, 2: ser_in tied high
  task automatic xfer(input logic [7:0] w, input int mode, input bit hold);
    logic [7:0] exp_rx;
    int b;
    exp_rx   = '0;
    tx_data  = w;
    tx_valid = 1'b1;
    loop     = (mode == 0);
    check("accept_ready", tx_ready, 1);
    check("accept_busy", busy, 0);
    step();
    for (int c = 0; c < 32; c++) begin
      b        = 7 - c / 4;
      tx_data  = 8'($urandom);
      tx_valid = hold ? 1'b1 : 1'($urandom);
      ser_drv  = (mode == 2) ? 1'b1 : 1'($urandom);
      if (c % 4 == 3) exp_rx[b] = (mode == 0) ? w[b] : ser_drv;
      check("shift_en", ser_en, 1);
      check("shift_busy", busy, 1);
      check("shift_ready", tx_ready, 0);
      check("shift_ser_out", ser_out, w[b]);
      check("shift_rx_valid", rx_valid, 0);
      check("shift_rx_hold", rx_data, last_rx);
      step();
    end
    tx_valid = hold ? 1'b1 : 1'($urandom);
    check("done_en", ser_en, 0);
    check("done_ser_out", ser_out, 0);
    check("done_busy", busy, 1);
    check("done_ready", tx_ready, 0);
    check("done_rx_valid", rx_valid, 0);
    step();
    check("out_rx_valid", rx_valid, 1);
    check("out_rx_data", rx_data, exp_rx);
    check("out_ready", tx_ready, 1);
    check("out_busy", busy, 0);
    check("out_en", ser_en, 0);
    last_rx = exp_rx;
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic idle_check();
    step();
    check("idle_rx_valid", rx_valid, 0);
    check("idle_rx_hold", rx_data, last_rx);
    check("idle_ready", tx_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  task automatic xfer1(input logic [3:0] w);
    tx_data1  = w;
    tx_valid1 = 1'b1;
    check("d1_ready", tx_ready1, 1);
    step();
    tx_valid1 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("d1_en", ser_en1, 1);
      check("d1_ser_out", ser_out1, w[3-c]);
      step();
    end
    check("d1_done_en", ser_en1, 0);
    check("d1_done_busy", busy1, 1);
    check("d1_done_rx_valid", rx_valid1, 0);
    step();
    check("d1_rx_valid", rx_valid1, 1);
    check("d1_rx_data", rx_data1, w);
    check("d1_out_ready", tx_ready1, 1);
  endtask

  initial begin
    reset     = 1'b0;
    tx_data   = '0;
    tx_valid  = 1'b0;
    ser_drv   = 1'b0;
    loop      = 1'b0;
    tx_data1  = '0;
    tx_valid1 = 1'b0;
    last_rx   = '0;
    #3;
    check("rst_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_en", ser_en, 0);
    check("rst_ser_out", ser_out, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    step();
    step();
    check("rst_hold_ready", tx_ready, 0);
    reset = 1'b1;
    check("release_ready_low", tx_ready, 0);
    step();
    check("release_ready_high", tx_ready, 1);
    check("release_ready1_high", tx_ready1, 1);

    xfer(8'hA5, 0, 1'b0);
    idle_check();
    xfer(8'h00, 2, 1'b0);
    idle_check();
    xfer(8'h3C, 0, 1'b1);
    xfer(8'hC3, 0, 1'b0);
    idle_check();
    for (int i = 0; i < 8; i++) begin
      xfer(8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
      tx_valid = 1'b0;
      idle_check();
    end

    // reset in the middle of a transfer
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    loop     = 1'b0;
    ser_drv  = 1'b0;
    step();
    tx_valid = 1'b0;
    for (int c = 0; c < 10; c++) step();
    check("pre_abort_ser_out", ser_out, 1);
    check("pre_abort_en", ser_en, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_en", ser_en, 0);
    check("abort_busy", busy, 0);
    check("abort_ser_out", ser_out, 0);
    check("abort_ready", tx_ready, 0);
    check("abort_rx_data", rx_data, 0);
    step();
    step();
    check("abort_hold_rx_valid", rx_valid, 0);
    check("abort_hold_en", ser_en, 0);
    reset = 1'b1;
    check("abort_release_ready_low", tx_ready, 0);
    step();
    check("abort_release_ready", tx_ready, 1);
    check("abort_rx_valid", rx_valid, 0);
    check("abort_release_busy", busy, 0);
    last_rx = '0;
    idle_check();

    xfer1(4'b1001);
    step();
    for (int i = 0; i < 3; i++) begin
      xfer1(4'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
